accel_spi_sampler: RTL and testbench
====================================

Name: accel_spi_sampler

Overview:
- Upstream producer for the LED debug stage: periodically reads one accelerometer axis register over 4-wire SPI (mode 3).
- Presents the result as a signed 8-bit sample on data, qualified by a one-cycle o_sync strobe.
- data and o_sync connect directly to the debug stage's data/o_sync inputs; data holds between strobes.

Parameters:
- CLK_DIV, 25: sys_clock cycles per SCLK half-period; must be ≥ 1.
- SAMPLE_PERIOD, 50000: sys_clock cycles between transaction triggers; must exceed the transaction length.
- REG_ADDR, 6'h32: 6-bit sensor register address (X-axis low byte).

Ports:
- sys_clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = periodic sampling runs.
- spi_miso  in  1  sensor serial data out.
- spi_cs_n  out  1  chip select, active low.
- spi_sclk  out  1  serial clock; idles high.
- spi_mosi  out  1  serial data to sensor.
- o_sync  out  1  one-cycle strobe; a new sample is valid on data.
- data  out  8  signed sample; updated only in the o_sync cycle.
- busy  out  1  high while a transaction is in flight (any state except IDLE).
- overrun  out  1  sticky; set when a trigger fires while busy.

Behaviour:
- Reset (synchronous, overrides everything, including mid-transaction):
  - State goes to IDLE; sample timer = 0.
  - spi_cs_n = 1, spi_sclk = 1, spi_mosi = 0.
  - o_sync = 0, data = 8'h00, busy = 0, overrun = 0.
- Sample timer:
  - Counts 0..SAMPLE_PERIOD-1 and wraps while enable = 1; held at 0 while enable = 0.
  - Trigger = timer at SAMPLE_PERIOD-1. The first trigger occurs SAMPLE_PERIOD cycles after enable rises.
- Trigger handling:
  - Trigger in IDLE starts a transaction.
  - Trigger while busy is dropped and sets overrun (stays set until reset).
  - Dropping enable mid-transaction does not abort; the transaction completes and strobes.
- FSM states: IDLE -> START -> SHIFT -> STOP -> DONE -> IDLE.
  - START: spi_cs_n = 0, spi_sclk = 1, held CLK_DIV cycles (CS setup).
  - SHIFT: N bits, MSB first. For each bit:
    - spi_sclk = 0 for CLK_DIV cycles; spi_mosi updates on the first cycle of the low phase.
    - spi_sclk = 1 for CLK_DIV cycles; spi_miso is captured on the cycle spi_sclk rises.
  - Command byte = {1'b1 (read), MB, REG_ADDR}. MB = 0 in the base build.
  - After the command byte, spi_mosi = 0 for the remaining bits.
  - STOP: spi_sclk = 1, spi_cs_n = 1, held CLK_DIV cycles (CS hold).
  - DONE: exactly one cycle; o_sync = 1 and data loads the result in that cycle; then IDLE.
- Base build:
  - N = 16; the final 8 captured bits form the result, passed to data unchanged.
  - Trigger to o_sync = 34*CLK_DIV + 1 cycles; o_sync is high one cycle only.
- Edge cases:
  - CLK_DIV = 1 must work; half-period counter wraps cleanly.
  - spi_sclk and spi_cs_n are registered outputs (no glitches).

Optional Feature:
- Macro: SPI_MB_READ_EN.
- Defined:
  - MB = 1; N = 24; captures byte0 (REG_ADDR) then byte1 (REG_ADDR+1).
  - raw = signed {byte1, byte0}; result = raw >>> 2, saturated to [-128, 127].
  - Trigger to o_sync = 50*CLK_DIV + 1 cycles.
- Undefined: single-byte read as in the base build.

Test Plan:
- Bench settings: CLK_DIV = 2, SAMPLE_PERIOD = 200, 10 ns sys_clock.
- Reset held 3 cycles, then released with enable = 1 -> all outputs at their reset values during reset; first spi_cs_n fall at cycle 200 after enable.
- Slave model returns 8'hC0 -> MOSI command byte observed = 8'hB2; exactly 16 SCLK rising edges; o_sync one cycle at trigger+69; data = 8'hC0 and held. Second sample 8'hA0 -> data = 8'hA0 at the next strobe.
- Assert reset mid-SHIFT (bit 7) -> next cycle spi_cs_n = 1, spi_sclk = 1, data = 0, no o_sync; sampling resumes after release.
- Force a trigger while busy (SAMPLE_PERIOD = 60) -> overrun = 1 and stays 1; in-flight transaction still strobes o_sync once.
- Drop enable during SHIFT -> the current transaction completes with one o_sync; no further spi_cs_n falls.
- With SPI_MB_READ_EN:
  - Command byte = 8'hF2 and 24 SCLK edges.
  - Bytes 8'h80, 8'hFF -> data = 8'hE0.
  - Bytes 8'h00, 8'h02 -> data = 8'h7F (saturated).
  - Bytes 8'h00, 8'hFC -> data = 8'h80.

Source files
------------

// File: rtl/accel_spi_sampler_if.sv
// 4-wire SPI bus between the accelerometer sampler (master) and the sensor (slave).
interface accel_spi_sampler_if;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_cs_n, output spi_sclk, output spi_mosi, input spi_miso);
  modport slave  (input spi_cs_n, input spi_sclk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/accel_spi_sampler.sv
// Periodically reads one accelerometer axis register over SPI mode 3 and strobes a signed 8-bit sample.
// Optional macro SPI_MB_READ_EN: two-byte multi-byte read, result = {byte1,byte0} >>> 2, saturated.
module accel_spi_sampler #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 50000,
  parameter logic [5:0]  REG_ADDR      = 6'h32
) (
  input  logic                       sys_clock,
  input  logic                       reset,
  input  logic                       enable,
  accel_spi_sampler_if.master        spi,
  output logic                       o_sync,
  output logic [7:0]                 data,
  output logic                       busy,
  output logic                       overrun
);

`ifdef SPI_MB_READ_EN
  localparam logic        MB    = 1'b1;
  localparam int unsigned NBITS = 24;
  localparam int unsigned CAP_W = 16;
`else
  localparam logic        MB    = 1'b0;
  localparam int unsigned NBITS = 16;
  localparam int unsigned CAP_W = 8;
`endif

  localparam int unsigned TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = $clog2(NBITS);

  localparam logic [7:0]    CMD        = {1'b1, MB, REG_ADDR};
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, DONE} state_t;

  state_t            state, state_nx;
  logic [TW-1:0]     timer;
  logic              trigger;
  logic [DW-1:0]     div_cnt, div_nx;
  logic [BW-1:0]     bit_cnt, bit_nx;
  logic              phase, phase_nx;
  logic              div_end;
  logic [CAP_W-1:0]  cap;
  logic              cs_n_q, sclk_q, mosi_q;
  logic              cs_n_nx, sclk_nx, mosi_nx;
  logic [7:0]        result_c;

  assign spi.spi_cs_n = cs_n_q;
  assign spi.spi_sclk = sclk_q;
  assign spi.spi_mosi = mosi_q;

  // Free-running sample timer, parked at zero while sampling is disabled
  always_ff @(posedge sys_clock) begin
    if (reset || !enable || timer == TIMER_LAST) timer <= '0;
    else                                         timer <= timer + TW'(1);
  end

  assign trigger = enable && (timer == TIMER_LAST);

  // Next state plus the registered SPI pin values that go with it
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    bit_nx   = bit_cnt;
    phase_nx = phase;
    div_end  = (div_cnt == DIV_LAST);
    mosi_nx  = mosi_q;

    case (state)
      IDLE: begin
        if (trigger) begin
          state_nx = START;
          div_nx   = '0;
        end
      end
      START: begin
        if (div_end) begin
          state_nx = SHIFT;
          div_nx   = '0;
          bit_nx   = '0;
          phase_nx = 1'b0;
        end else begin
          div_nx = div_cnt + DW'(1);
        end
      end
      SHIFT: begin
        if (div_end) begin
          div_nx = '0;
          if (!phase) begin
            phase_nx = 1'b1;
          end else if (bit_cnt == BIT_LAST) begin
            state_nx = STOP;
          end else begin
            bit_nx   = bit_cnt + BW'(1);
            phase_nx = 1'b0;
          end
        end else begin
          div_nx = div_cnt + DW'(1);
        end
      end
      STOP: begin
        if (div_end) begin
          state_nx = DONE;
          div_nx   = '0;
        end else begin
          div_nx = div_cnt + DW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    cs_n_nx = !(state_nx == START || state_nx == SHIFT);
    sclk_nx = !(state_nx == SHIFT && !phase_nx);

    // MOSI changes only on the first cycle of each low phase; command byte then zeros
    if (state_nx != SHIFT) begin
      mosi_nx = 1'b0;
    end else if (!phase_nx && div_nx == '0) begin
      mosi_nx = (bit_nx < BW'(8)) ? CMD[3'(7 - bit_nx)] : 1'b0;
    end
  end

`ifdef SPI_MB_READ_EN
  logic signed [15:0] raw;
  logic signed [15:0] shifted;

  assign raw     = {cap[7:0], cap[15:8]};
  assign shifted = raw >>> 2;

  always_comb begin
    result_c = shifted[7:0];
    if (shifted > 16'sd127)       result_c = 8'h7F;
    else if (shifted < -16'sd128) result_c = 8'h80;
  end
`else
  assign result_c = cap;
`endif

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      cap     <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      o_sync  <= 1'b0;
      data    <= 8'h00;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
      phase   <= phase_nx;
      cs_n_q  <= cs_n_nx;
      sclk_q  <= sclk_nx;
      mosi_q  <= mosi_nx;
      o_sync  <= (state_nx == DONE);
      busy    <= (state_nx != IDLE);
      if (state_nx == DONE) data <= result_c;
      if (trigger && state != IDLE) overrun <= 1'b1;
      // MISO sampled in the first cycle SCLK is high
      if (state == SHIFT && phase && div_cnt == '0) cap <= {cap[CAP_W-2:0], spi.spi_miso};
    end
  end

endmodule

// File: tb/tb_accel_spi_sampler.sv
// Directed bench for accel_spi_sampler: sensor slave model, scoreboard of expected samples.
module tb_accel_spi_sampler;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned PERIOD    = 200;
  localparam int unsigned PERIOD_OV = 60;
`ifdef SPI_MB_READ_EN
  localparam int         NBITS   = 24;
  localparam logic [7:0] CMD_EXP = 8'hF2;
  localparam int         LAT     = 50 * CLK_DIV + 1;
`else
  localparam int         NBITS   = 16;
  localparam logic [7:0] CMD_EXP = 8'hB2;
  localparam int         LAT     = 34 * CLK_DIV + 1;
`endif
  localparam int NTX = 3;

  logic clk  = 1'b0;
  logic rst0 = 1'b1, en0 = 1'b0, rst1 = 1'b1, en1 = 1'b0;
  logic miso0 = 1'b0;
  logic o_sync0, busy0, ovr0, o_sync1, busy1, ovr1;
  logic [7:0] data0, data1;

  accel_spi_sampler_if if0();
  accel_spi_sampler_if if1();

  assign if0.spi_miso = miso0;
  assign if1.spi_miso = 1'b0;

  accel_spi_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(PERIOD), .REG_ADDR(6'h32)) dut (
    .sys_clock(clk), .reset(rst0), .enable(en0), .spi(if0),
    .o_sync(o_sync0), .data(data0), .busy(busy0), .overrun(ovr0));

  accel_spi_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(PERIOD_OV), .REG_ADDR(6'h32)) dut_ov (
    .sys_clock(clk), .reset(rst1), .enable(en1), .spi(if1),
    .o_sync(o_sync1), .data(data1), .busy(busy1), .overrun(ovr1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SPI_MB_READ_EN
  logic [7:0] tx_b0 [NTX] = '{8'h80, 8'h00, 8'h00};
  logic [7:0] tx_b1 [NTX] = '{8'hFF, 8'h02, 8'hFC};
`else
  logic [7:0] tx_b0 [NTX] = '{8'hC0, 8'hA0, 8'h3F};
`endif

  logic [23:0] sl_word = '0, sl_sh = '0, mosi_sh = '0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1;
  int sclk_rises = 0, csfall_cnt0 = 0, sync_cnt0 = 0, sync_cnt1 = 0;
  logic [7:0] exp_q[$];
  int checks = 0, errors = 0;

  // Sensor model (mode 3: drive on SCLK fall) and bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (prev_cs && !if0.spi_cs_n) begin
      sl_sh       <= sl_word;
      sclk_rises  <= 0;
      mosi_sh     <= '0;
      csfall_cnt0 <= csfall_cnt0 + 1;
    end else if (!if0.spi_cs_n) begin
      if (prev_sclk && !if0.spi_sclk) begin
        miso0 <= sl_sh[23];
        sl_sh <= sl_sh << 1;
      end
      if (!prev_sclk && if0.spi_sclk) begin
        sclk_rises <= sclk_rises + 1;
        mosi_sh    <= {mosi_sh[22:0], if0.spi_mosi};
      end
    end
    if (o_sync0) sync_cnt0 <= sync_cnt0 + 1;
    if (o_sync1) sync_cnt1 <= sync_cnt1 + 1;
    prev_cs   <= if0.spi_cs_n;
    prev_sclk <= if0.spi_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef SPI_MB_READ_EN
  function automatic logic [7:0] model(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = int'($signed({hi, lo}));
    v = v >>> 2;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return 8'(v);
  endfunction
`endif

  task automatic load_tx(input int k);
`ifdef SPI_MB_READ_EN
    sl_word = {8'h00, tx_b0[k], tx_b1[k]};
    exp_q.push_back(model(tx_b0[k], tx_b1[k]));
`else
    sl_word = {8'h00, tx_b0[k], 8'h00};
    exp_q.push_back(tx_b0[k]);
`endif
  endtask

  task automatic wait_cs_low(input int lim);
    int n = 0;
    while (if0.spi_cs_n !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("cs_fall_seen", 32'(if0.spi_cs_n), 0);
  endtask

  task automatic wait_sync(input int lim);
    int n = 0;
    while (o_sync0 !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("o_sync_seen", 32'(o_sync0), 1);
  endtask

  // One full transaction: trigger cycle returned, latency/command/edges/data checked
  task automatic run_tx(input int k, input int drop_after, output int trig);
    logic [7:0] e;
    load_tx(k);
    wait_cs_low(1000);
    trig = cyc - 1;
    if (drop_after > 0) begin
      repeat (drop_after) @(negedge clk);
      en0 = 1'b0;
    end
    wait_sync(300);
    chk("latency", 32'(cyc - trig), 32'(LAT));
    chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    chk("data", 32'(data0), 32'(e));
    chk("cmd_byte", 32'(8'(mosi_sh >> (NBITS - 8))), 32'(CMD_EXP));
    chk("mosi_tail", 32'(mosi_sh & ((24'h1 << (NBITS - 8)) - 24'h1)), 0);
    chk("sclk_rises", 32'(sclk_rises), 32'(NBITS));
    @(negedge clk);
    chk("o_sync_one_cycle", 32'(o_sync0), 0);
    chk("data_hold", 32'(data0), 32'(e));
  endtask

  initial begin
    int en_cyc, trig, prev_trig, rel, snap_s, snap_c, n1;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(if0.spi_cs_n), 1);
    chk("rst_sclk", 32'(if0.spi_sclk), 1);
    chk("rst_mosi", 32'(if0.spi_mosi), 0);
    chk("rst_o_sync", 32'(o_sync0), 0);
    chk("rst_data", 32'(data0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_overrun", 32'(ovr0), 0);
    chk("rst_ov_cs_n", 32'(if1.spi_cs_n), 1);

    en_cyc = cyc;
    rst0 = 1'b0;
    en0  = 1'b1;
    prev_trig = 0;
    for (int k = 0; k < NTX; k++) begin
      run_tx(k, 0, trig);
      if (k == 0) chk("first_cs_fall", 32'(trig + 1 - en_cyc), PERIOD);
      else        chk("period", 32'(trig - prev_trig), PERIOD);
      prev_trig = trig;
    end
    chk("no_overrun", 32'(ovr0), 0);

    // Reset in the low phase of bit 7
    load_tx(0);
    wait_cs_low(1000);
    repeat (15 * CLK_DIV) @(negedge clk);
    snap_s = sync_cnt0;
    rst0 = 1'b1;
    @(negedge clk);
    chk("midrst_cs_n", 32'(if0.spi_cs_n), 1);
    chk("midrst_sclk", 32'(if0.spi_sclk), 1);
    chk("midrst_data", 32'(data0), 0);
    chk("midrst_o_sync", 32'(o_sync0), 0);
    chk("midrst_busy", 32'(busy0), 0);
    exp_q.delete();
    @(negedge clk);
    rel  = cyc;
    rst0 = 1'b0;
    run_tx(1, 0, trig);
    chk("resume_cs_fall", 32'(trig + 1 - rel), PERIOD);
    chk("midrst_no_sync", 32'(sync_cnt0 - snap_s), 1);

    // Enable dropped during SHIFT: transaction finishes, nothing further starts
    run_tx(2, 10, trig);
    repeat (2) @(negedge clk);
    snap_s = sync_cnt0;
    snap_c = csfall_cnt0;
    repeat (3 * PERIOD) @(negedge clk);
    chk("drop_no_cs_fall", 32'(csfall_cnt0 - snap_c), 0);
    chk("drop_no_sync", 32'(sync_cnt0 - snap_s), 0);
    chk("drop_idle", 32'(busy0), 0);

    // Overrun on the short-period instance
    n1 = cyc;
    snap_s = sync_cnt1;
    rst1 = 1'b0;
    en1  = 1'b1;
    repeat (118) @(negedge clk);
    chk("ov_busy", 32'(busy1), 1);
    chk("ov_clear", 32'(ovr1), 0);
    repeat (3) @(negedge clk);
    chk("ov_set", 32'(ovr1), 1);
    repeat (54) @(negedge clk);
    chk("ov_one_sync", 32'(sync_cnt1 - snap_s), 1);
    repeat (300) @(negedge clk);
    chk("ov_sticky", 32'(ovr1), 1);
    chk("ov_elapsed", 32'(cyc - n1), 475);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
